// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage core: a shadow D/E/M/W pipeline drives stalls, flushes and E-operand forwards.
// Latency: every output is combinational from shadow state and current inputs; shadow state advances on each edge.
// Backpressure: a data-memory wait freezes F/D/E/M and drains W; load-use and pending branches stall the front end.
module hazard_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RsD,
    input  logic       UsesRsD,
    input  logic [3:0] RdD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic       MemWriteD,
    input  logic       PCSrcD,
    input  logic       CondExE,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       StallEM,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic [1:0] ForwardSE
);

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       pc_src;
    } stage_t;

    typedef struct packed {
        stage_t     ctl;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] rs;
        logic       uses_rs;
    } ex_stage_t;

    // W keeps only what forwarding and the PC redirect observe.
    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       reg_write;
        logic       pc_src;
    } wb_stage_t;

    logic      valid_d_q, valid_d_d;
    ex_stage_t ex_q, ex_d;
    stage_t    mem_q, mem_d;
    wb_stage_t wb_q, wb_d;

    ex_stage_t dec;
    logic      memwait;
    logic      ldstall;
    logic      bpend;
    logic      redirect_w;

    function automatic logic load_hit(input stage_t e, input logic [3:0] r);
        return e.valid & e.reg_write & e.mem_to_reg & (e.rd == r) & (r != 4'd15);
    endfunction

    // R15 reads come from the regfile as PC+8, so they are never forwarded.
    function automatic logic [1:0] fwd_sel(input stage_t m, input wb_stage_t w, input logic [3:0] s);
        logic [1:0] sel;
        sel = 2'b00;
        if (m.valid & m.reg_write & (m.rd == s) & (s != 4'd15)) begin
            sel = 2'b10;
        end else if (w.valid & w.reg_write & (w.rd == s) & (s != 4'd15)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        dec = '0;
        if (valid_d_q) begin
            dec.ctl.valid      = 1'b1;
            dec.ctl.rd         = RdD;
            dec.ctl.reg_write  = RegWriteD;
            dec.ctl.mem_to_reg = MemtoRegD;
            dec.ctl.mem_write  = MemWriteD;
            dec.ctl.pc_src     = PCSrcD;
            dec.ra1            = RA1D;
            dec.ra2            = RA2D;
            dec.rs             = RsD;
            dec.uses_rs        = UsesRsD;
        end
    end

    always_comb begin
        memwait    = mem_q.valid & (mem_q.mem_to_reg | mem_q.mem_write) & ~MemReadyM;
        ldstall    = valid_d_q & (load_hit(ex_q.ctl, RA1D) | load_hit(ex_q.ctl, RA2D)
                                  | (UsesRsD & load_hit(ex_q.ctl, RsD)));
        bpend      = (valid_d_q & PCSrcD) | (ex_q.ctl.valid & ex_q.ctl.pc_src)
                   | (mem_q.valid & mem_q.pc_src);
        redirect_w = wb_q.valid & wb_q.pc_src;
    end

    always_comb begin
        StallF    = memwait | ldstall | bpend;
        StallD    = memwait | ldstall;
        StallEM   = memwait;
        FlushW    = memwait;
        FlushD    = ~StallD & (bpend | redirect_w);
        FlushE    = ~memwait & ldstall;
        ForwardAE = fwd_sel(mem_q, wb_q, ex_q.ra1);
        ForwardBE = fwd_sel(mem_q, wb_q, ex_q.ra2);
        ForwardSE = fwd_sel(mem_q, wb_q, ex_q.rs);
    end

    always_comb begin
        valid_d_d = valid_d_q;
        ex_d      = ex_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        if (memwait) begin
            wb_d = '0;
        end else begin
            wb_d.valid     = mem_q.valid;
            wb_d.rd        = mem_q.rd;
            wb_d.reg_write = mem_q.reg_write;
            wb_d.pc_src    = mem_q.pc_src;

            // A failed condition in E cancels both the register write and the redirect.
            mem_d            = ex_q.ctl;
            mem_d.reg_write  = ex_q.ctl.reg_write & CondExE;
            mem_d.mem_to_reg = ex_q.ctl.mem_to_reg & CondExE;
            mem_d.mem_write  = ex_q.ctl.mem_write & CondExE;
            mem_d.pc_src     = ex_q.ctl.pc_src & CondExE;

            ex_d = FlushE ? '0 : dec;

            if (!StallD) begin
                valid_d_d = ~FlushD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_d_q <= 1'b0;
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
        end else begin
            valid_d_q <= valid_d_d;
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with hand-computed expectations, then randomized traffic
// checked every cycle against a behavioural pipeline model.
module tb_hazard_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] RA1D, RA2D, RsD, RdD;
    logic       UsesRsD, RegWriteD, MemtoRegD, MemWriteD, PCSrcD, CondExE, MemReadyM;
    logic       StallF, StallD, FlushD, FlushE, StallEM, FlushW;
    logic [1:0] ForwardAE, ForwardBE, ForwardSE;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RsD(RsD), .UsesRsD(UsesRsD), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .PCSrcD(PCSrcD),
        .CondExE(CondExE), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallEM(StallEM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardSE(ForwardSE)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] rd;
        logic       rw;
        logic       m2r;
        logic       mw;
        logic       pcs;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] rs;
        logic       uses;
    } rec_t;

    // Model pipeline slots: 0=D (only v used), 1=E, 2=M, 3=W.
    rec_t mp [4];
    logic model_ok = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic rec_t mk(input logic [3:0] rd, input logic rw, input logic m2r, input logic mw,
                                input logic pcs, input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic [3:0] rs, input logic uses);
        rec_t r;
        r.v = 1'b1; r.rd = rd; r.rw = rw; r.m2r = m2r; r.mw = mw; r.pcs = pcs;
        r.ra1 = ra1; r.ra2 = ra2; r.rs = rs; r.uses = uses;
        return r;
    endfunction

    function automatic rec_t decode_view();
        rec_t r;
        r = '0;
        if (mp[0].v) r = mk(RdD, RegWriteD, MemtoRegD, MemWriteD, PCSrcD, RA1D, RA2D, RsD, UsesRsD);
        return r;
    endfunction

    function automatic bit load_in(input rec_t e, input logic [3:0] r);
        return e.v && e.rw && e.m2r && e.rd == r && r != 4'd15;
    endfunction

    function automatic bit writes(input rec_t x, input logic [3:0] r);
        return x.v && x.rw && x.rd == r && r != 4'd15;
    endfunction

    function automatic logic [1:0] fw(input rec_t m, input rec_t w, input logic [3:0] s);
        if (writes(m, s)) return 2'b10;
        if (writes(w, s)) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF, StallD, FlushD, FlushE, StallEM, FlushW, FwdA, FwdB, FwdS}
    function automatic logic [11:0] model_out();
        rec_t d, e, m, w;
        bit   mwt, ld, br, sd;
        d = decode_view(); e = mp[1]; m = mp[2]; w = mp[3];
        mwt = m.v && (m.m2r || m.mw) && !MemReadyM;
        ld  = d.v && (load_in(e, d.ra1) || load_in(e, d.ra2) || (d.uses && load_in(e, d.rs)));
        br  = (d.v && d.pcs) || (e.v && e.pcs) || (m.v && m.pcs);
        sd  = mwt || ld;
        return {mwt || ld || br, sd, !sd && (br || (w.v && w.pcs)), !mwt && ld, mwt, mwt,
                fw(m, w, e.ra1), fw(m, w, e.ra2), fw(m, w, e.rs)};
    endfunction

    always @(posedge clk) begin : model_adv
        rec_t        nx [4];
        logic [11:0] o;
        nx = mp;
        if (reset) begin
            for (int i = 0; i < 4; i++) nx[i] = '0;
        end else if (model_ok) begin
            o = model_out();
            if (o[7]) begin
                nx[3] = '0;
            end else begin
                nx[3] = mp[2];
                nx[2] = mp[1];
                nx[2].rw  = mp[1].rw & CondExE;
                nx[2].m2r = mp[1].m2r & CondExE;
                nx[2].mw  = mp[1].mw & CondExE;
                nx[2].pcs = mp[1].pcs & CondExE;
                nx[1] = o[8] ? rec_t'('0) : decode_view();
                if (!o[10]) nx[0].v = !o[9];
            end
        end
        for (int i = 0; i < 4; i++) mp[i] <= nx[i];
        if (reset) model_ok <= 1'b1;
    end

    function automatic logic [11:0] dut_out();
        return {StallF, StallD, FlushD, FlushE, StallEM, FlushW, ForwardAE, ForwardBE, ForwardSE};
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%b required=%b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input rec_t ins, input logic cond, input logic rdy, input logic rst);
        @(posedge clk);
        #1;
        reset = rst;
        RA1D = ins.ra1; RA2D = ins.ra2; RsD = ins.rs; UsesRsD = ins.uses; RdD = ins.rd;
        RegWriteD = ins.rw; MemtoRegD = ins.m2r; MemWriteD = ins.mw; PCSrcD = ins.pcs;
        CondExE = cond; MemReadyM = rdy;
        @(negedge clk);
        if (model_ok) chk("model", dut_out(), model_out());
    endtask

    rec_t nop, ldr2, add_r2, w4, rd4, w15, rd15, br, cons;

    task automatic do_reset();
        cyc(nop, 1'b1, 1'b1, 1'b1);
        cyc(nop, 1'b1, 1'b1, 1'b1);
        cyc(nop, 1'b1, 1'b1, 1'b0);
    endtask

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'd15;
    endfunction

    initial begin
        nop    = '0;
        ldr2   = mk(4'd2, 1, 1, 0, 0, 4'd6, 4'd7, 4'd0, 0);
        add_r2 = mk(4'd3, 1, 0, 0, 0, 4'd2, 4'd1, 4'd0, 0);
        w4     = mk(4'd4, 1, 0, 0, 0, 4'd8, 4'd9, 4'd0, 0);
        rd4    = mk(4'd5, 1, 0, 0, 0, 4'd4, 4'd1, 4'd0, 0);
        w15    = mk(4'd15, 1, 0, 0, 0, 4'd8, 4'd9, 4'd0, 0);
        rd15   = mk(4'd6, 1, 0, 0, 0, 4'd15, 4'd15, 4'd15, 1);
        br     = mk(4'd0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 0);
        cons   = mk(4'd3, 1, 0, 0, 0, 4'd2, 4'd1, 4'd0, 0);
        reset = 1'b1; RA1D = 0; RA2D = 0; RsD = 0; UsesRsD = 0; RdD = 0;
        RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; PCSrcD = 0; CondExE = 1; MemReadyM = 1;

        // Reset while a load waits on memory.
        do_reset();
        cyc(ldr2, 1, 1, 0);
        cyc(nop, 1, 1, 0);
        cyc(nop, 1, 0, 1);
        chk("memwait_before_reset", 12'(StallEM), 12'd1);
        cyc(br, 1, 0, 0);
        chk("post_reset_ctrl", 12'({StallF, StallD, FlushD, FlushE, StallEM, FlushW}), 12'd0);
        chk("post_reset_fwd", 12'({ForwardAE, ForwardBE, ForwardSE}), 12'd0);

        // Load-use: one stall cycle, then W forwarding.
        do_reset();
        cyc(ldr2, 1, 1, 0);
        cyc(add_r2, 1, 1, 0);
        chk("lduse_stall", 12'({StallF, StallD, FlushE, FlushD}), 12'b1110);
        cyc(add_r2, 1, 1, 0);
        chk("lduse_release", 12'({StallF, StallD, FlushE}), 12'b000);
        cyc(nop, 1, 1, 0);
        chk("lduse_fwd", 12'({ForwardAE, ForwardBE}), 12'b0100);

        // Two writers of R4: M wins over W.
        do_reset();
        cyc(w4, 1, 1, 0);
        cyc(w4, 1, 1, 0);
        cyc(rd4, 1, 1, 0);
        cyc(nop, 1, 1, 0);
        chk("m_over_w", 12'({ForwardAE, ForwardBE}), 12'b1000);

        // R15 never forwarded.
        do_reset();
        cyc(w15, 1, 1, 0);
        cyc(rd15, 1, 1, 0);
        cyc(nop, 1, 1, 0);
        chk("r15_fwd", 12'({ForwardAE, ForwardBE, ForwardSE}), 12'd0);

        // Taken branch: StallF 3 cycles, FlushD 4 cycles.
        do_reset();
        cyc(br, 1, 1, 0);
        chk("tb_t0", 12'({StallF, FlushD, StallD}), 12'b110);
        cyc(nop, 1, 1, 0);
        chk("tb_t1", 12'({StallF, FlushD, StallD}), 12'b110);
        cyc(nop, 1, 1, 0);
        chk("tb_t2", 12'({StallF, FlushD, StallD}), 12'b110);
        cyc(nop, 1, 1, 0);
        chk("tb_t3", 12'({StallF, FlushD}), 12'b01);
        cyc(nop, 1, 1, 0);
        chk("tb_t4", 12'({StallF, FlushD}), 12'b00);

        // Untaken branch: two cycles, redirect never reaches W.
        do_reset();
        cyc(br, 1, 1, 0);
        chk("ub_t0", 12'({StallF, FlushD}), 12'b11);
        cyc(nop, 0, 1, 0);
        chk("ub_t1", 12'({StallF, FlushD}), 12'b11);
        cyc(nop, 1, 1, 0);
        chk("ub_t2", 12'({StallF, FlushD}), 12'b00);
        cyc(nop, 1, 1, 0);
        chk("ub_t3", 12'({StallF, FlushD}), 12'b00);

        // Load waiting three cycles on memory.
        do_reset();
        cyc(ldr2, 1, 1, 0);
        cyc(nop, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(nop, 1, 0, 0);
            chk("memwait_hold", 12'({StallF, StallD, StallEM, FlushW, FlushE}), 12'b11110);
        end
        cyc(cons, 1, 1, 0);
        chk("memwait_release", 12'({StallF, StallD, StallEM, FlushW, FlushE}), 12'b00000);
        cyc(nop, 1, 1, 0);
        chk("memwait_load_in_w", 12'(ForwardAE), 12'b01);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rec_t r;
            r = mk(rreg(), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom_range(0, 5) == 0),
                   1'($urandom_range(0, 7) == 0), rreg(), rreg(), rreg(), 1'($urandom % 2));
            cyc(r, 1'($urandom % 2), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
